// File: rtl/mem_demux.sv
// Receive-side memory demux: unpacks the 54-bit link stream and routes each data
// word to one of 12 destination memories with per-BX write addresses and status.
module mem_demux #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [53:0]       stream_in,
  output logic [11:0]       wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_bx,
  output logic [44:0]       wr_dat,
  output logic              bx_new,
  output logic [2:0]        bx_prev,
  output logic [11:0]       ovf,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int unsigned N_DST = 12;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [53:0]      s1;
  logic [CNT_W-1:0] cnt [N_DST];
  logic [2:0]       cur_bx;
  logic             have_bx;

  logic [1:0]       hdr;
  logic [2:0]       bx;
  logic [3:0]       sel;
  logic [44:0]      dat;
  logic             is_data;
  logic             is_bad;
  logic [3:0]       dst;
  logic             new_bx;
  logic [CNT_W-1:0] cnt_sel;
  logic             full;

  assign hdr = s1[53:52];
  assign bx  = s1[51:49];
  assign sel = s1[48:45];
  assign dat = s1[44:0];

  // Classify the stage-1 word and map sel to a destination index
  always_comb begin
    is_data = 1'b0;
    is_bad  = 1'b0;
    dst     = 4'd0;
    unique case (hdr)
      2'b00: ;
      2'b01: begin
        unique case (sel)
          4'b1111: ;
          4'b0000, 4'b1010, 4'b1110: is_bad = 1'b1;
          4'b1011: begin is_data = 1'b1; dst = 4'd9;  end
          4'b1100: begin is_data = 1'b1; dst = 4'd10; end
          4'b1101: begin is_data = 1'b1; dst = 4'd11; end
          default: begin is_data = 1'b1; dst = sel - 4'd1; end
        endcase
      end
      default: is_bad = 1'b1;
    endcase
  end

  // A new BX restarts every counter, so the selected address is 0 in that case
  always_comb begin
    new_bx  = is_data && (!have_bx || (bx != cur_bx));
    cnt_sel = new_bx ? '0 : cnt[dst];
    full    = (cnt_sel == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1      <= '0;
      cur_bx  <= '0;
      have_bx <= 1'b0;
      wr_en   <= '0;
      wr_addr <= '0;
      wr_bx   <= '0;
      wr_dat  <= '0;
      bx_new  <= 1'b0;
      bx_prev <= '0;
      ovf     <= '0;
      err_cnt <= '0;
      for (int k = 0; k < N_DST; k++) cnt[k] <= '0;
    end else begin
      s1     <= stream_in;
      wr_en  <= '0;
      bx_new <= 1'b0;

      if (is_bad && (err_cnt != {ERR_W{1'b1}}))
        err_cnt <= err_cnt + ERR_W'(1);

      if (is_data) begin
        if (new_bx) begin
          for (int k = 0; k < N_DST; k++) cnt[k] <= '0;
          ovf     <= '0;
          bx_new  <= 1'b1;
          bx_prev <= have_bx ? cur_bx : 3'd0;
          cur_bx  <= bx;
          have_bx <= 1'b1;
        end
        // Full destination: drop the word, park the counter and flag overflow
        if (full) begin
          ovf[dst] <= 1'b1;
        end else begin
          wr_en    <= N_DST'(1) << dst;
          wr_addr  <= cnt_sel[ADDR_W-1:0];
          wr_bx    <= bx;
          wr_dat   <= dat;
          cnt[dst] <= cnt_sel + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_demux.sv
// Scoreboard bench for mem_demux: a behavioural model predicts every output cycle,
// expectations are queued at drive time and compared two clocks later.
module tb_mem_demux;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [53:0] stream_in = '0;
  logic [11:0] wr_en;
  logic [5:0]  wr_addr;
  logic [2:0]  wr_bx;
  logic [44:0] wr_dat;
  logic        bx_new;
  logic [2:0]  bx_prev;
  logic [11:0] ovf;
  logic [7:0]  err_cnt;

  mem_demux #(.ADDR_W(6), .ERR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .stream_in(stream_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_bx(wr_bx), .wr_dat(wr_dat),
    .bx_new(bx_new), .bx_prev(bx_prev), .ovf(ovf), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] en;
    logic [5:0]  addr;
    logic [2:0]  bx;
    logic [44:0] dat;
    logic        nw;
    logic [2:0]  prev;
    logic [11:0] ovf;
    logic [7:0]  err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int          m_cnt [12];
  logic [2:0]  m_cur;
  logic        m_have;
  logic [11:0] m_ovf;
  int          m_err;
  logic [5:0]  m_addr;
  logic [2:0]  m_bx;
  logic [44:0] m_dat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dst_of(input logic [3:0] sel);
    case (sel)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: return int'(sel) - 1;
      4'd11: return 9;
      4'd12: return 10;
      4'd13: return 11;
      default: return -1;
    endcase
  endfunction

  function automatic logic [53:0] mk(input logic [1:0] h, input logic [2:0] b,
                                     input logic [3:0] s);
    logic [44:0] d;
    d = {13'($urandom), $urandom};
    return {h, b, s, d};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 12; k++) m_cnt[k] = 0;
    m_cur = '0; m_have = 1'b0; m_ovf = '0; m_err = 0;
    m_addr = '0; m_bx = '0; m_dat = '0;
  endtask

  task automatic model(input logic [53:0] w, output exp_t e);
    logic [1:0] h;
    logic [2:0] b;
    logic [3:0] s;
    int d;
    h = w[53:52]; b = w[51:49]; s = w[48:45];
    d = dst_of(s);
    e = '0;
    if (h == 2'b01 && s == 4'b1111) begin
    end else if (h == 2'b01 && d >= 0) begin
      if (!m_have || b != m_cur) begin
        for (int k = 0; k < 12; k++) m_cnt[k] = 0;
        m_ovf  = '0;
        e.nw   = 1'b1;
        e.prev = m_have ? m_cur : 3'd0;
        m_cur  = b;
        m_have = 1'b1;
      end
      if (m_cnt[d] == 64) begin
        m_ovf[d] = 1'b1;
      end else begin
        e.en[d] = 1'b1;
        m_addr  = 6'(m_cnt[d]);
        m_bx    = b;
        m_dat   = w[44:0];
        m_cnt[d]++;
      end
    end else if (h != 2'b00) begin
      if (m_err < 255) m_err++;
    end
    e.addr = m_addr; e.bx = m_bx; e.dat = m_dat;
    e.ovf  = m_ovf;  e.err = 8'(m_err);
  endtask

  // Compare the word driven two clocks ago, then drive the next one
  task automatic step(input logic [53:0] w);
    exp_t e, o;
    @(negedge clk);
    if (q.size() == 2) begin
      o = q.pop_front();
      check("wr_en",   64'(wr_en),   64'(o.en));
      check("wr_addr", 64'(wr_addr), 64'(o.addr));
      check("wr_bx",   64'(wr_bx),   64'(o.bx));
      check("wr_dat",  64'(wr_dat),  64'(o.dat));
      check("bx_new",  64'(bx_new),  64'(o.nw));
      if (o.nw) check("bx_prev", 64'(bx_prev), 64'(o.prev));
      check("ovf",     64'(ovf),     64'(o.ovf));
      check("err_cnt", 64'(err_cnt), 64'(o.err));
    end
    stream_in = w;
    model(w, e);
    q.push_back(e);
  endtask

  task automatic do_reset(input int n, input logic [53:0] w);
    @(negedge clk);
    reset_n   = 1'b0;
    stream_in = w;
    q.delete();
    model_reset();
    repeat (n) @(negedge clk);
    check("rst_wr_en",   64'(wr_en),   64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_bx_new",  64'(bx_new),  64'd0);
    check("rst_ovf",     64'(ovf),     64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_wr_dat",  64'(wr_dat),  64'd0);
    reset_n   = 1'b1;
    stream_in = '0;
  endtask

  task automatic flush();
    repeat (3) step('0);
  endtask

  initial begin
    model_reset();
    do_reset(3, '0);

    // Idle stream
    repeat (10) step('0);

    // Basic routing, first word opens BX 3
    step(mk(2'b01, 3'd3, 4'b0001));
    step(mk(2'b01, 3'd3, 4'b0001));
    step(mk(2'b01, 3'd3, 4'b1101));
    flush();

    // Malformed words and an ignored header word
    step(mk(2'b01, 3'd3, 4'b1010));
    step(mk(2'b01, 3'd3, 4'b0000));
    step(mk(2'b11, 3'd3, 4'b0001));
    step(mk(2'b01, 3'd4, 4'b1111));
    flush();
    check("err_after_bad", 64'(err_cnt), 64'd3);

    // Overflow of destination 2 in BX 5, then recovery on BX 6
    repeat (65) step(mk(2'b01, 3'd5, 4'b0011));
    flush();
    check("ovf_set", 64'(ovf), 64'h004);
    check("ovf_last_addr", 64'(wr_addr), 64'd63);
    step(mk(2'b01, 3'd6, 4'b0011));
    flush();
    check("ovf_clear", 64'(ovf), 64'd0);
    check("bx6_addr", 64'(wr_addr), 64'd0);
    check("bx6_prev", 64'(bx_prev), 64'd5);

    // BX change restarts counters
    step(mk(2'b01, 3'd1, 4'b0101));
    step(mk(2'b01, 3'd2, 4'b0101));
    flush();
    check("bx2_addr", 64'(wr_addr), 64'd0);
    check("bx2_prev", 64'(bx_prev), 64'd1);

    // Reset mid-BX with traffic still arriving
    repeat (3) step(mk(2'b01, 3'd7, 4'b0001));
    flush();
    do_reset(3, mk(2'b01, 3'd7, 4'b0001));
    step(mk(2'b01, 3'd7, 4'b0001));
    flush();
    check("post_rst_addr", 64'(wr_addr), 64'd0);
    check("post_rst_prev", 64'(bx_prev), 64'd0);
    check("post_rst_en",   64'(wr_en),   64'd0);

    // Mixed random traffic
    for (int i = 0; i < 200; i++)
      step(mk(($urandom_range(0, 9) < 7) ? 2'b01 : 2'($urandom),
              3'($urandom_range(0, 1)), 4'($urandom)));
    flush();

    // Error counter saturation
    repeat (300) step(mk(2'b10, 3'($urandom), 4'($urandom)));
    flush();
    check("err_sat", 64'(err_cnt), 64'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_demux.md
Name: mem_demux

Overview:
- Receive-side counterpart of the link memory mux: unpacks the 54-bit memory data stream and routes each word to one of 12 destination memories.
- Generates per-destination write addresses that restart at every new bunch crossing (BX), plus error and overflow status.
- Sits at the far end of the link, between the stream receiver and the 12 downstream memory write ports.

Parameters:
- ADDR_W, 6, width of per-destination write address; each destination holds DEPTH = 2^ADDR_W words per BX.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- stream_in  in  54  packed word: [53:52] header, [51:49] BX, [48:45] sel, [44:0] data.
- wr_en  out  12  one-hot write strobe; bit k = destination k.
- wr_addr  out  ADDR_W  write address for the strobed destination.
- wr_bx  out  3  BX of the written word.
- wr_dat  out  45  payload.
- bx_new  out  1  one-cycle pulse when a valid word opens a new BX.
- bx_prev  out  3  BX just closed; valid when bx_new=1.
- ovf  out  12  sticky per-destination overflow flags.
- err_cnt  out  ERR_W  saturating count of malformed words.

Behaviour:
- Reset (reset_n=0 at a rising clk edge):
  - All outputs go to 0.
  - All 12 address counters clear.
  - The have_bx flag clears.
  - Reset mid-BX discards the current BX; the next valid word is treated as a new BX.
- Pipeline:
  - Stage 1 registers stream_in.
  - Stage 2 decodes and registers all outputs.
  - A word sampled at edge N appears on the outputs after edge N+1 (latency 2 clocks), at a throughput of 1 word/clock.
- Word classification (stage-1 contents):
  - header 2'b00: idle, no action, all other bits ignored.
  - header 2'b01 with sel valid: data word.
  - header 2'b01 with sel=4'b1111: header word, ignored, not an error.
  - header 2'b01 with sel in {0000, 1010, 1110}: malformed.
  - header 2'b10 or 2'b11: malformed.
- sel-to-destination map (fixed, matches the transmit mux):
  - sel 0001–1001 → destinations 0–8.
  - sel 1011 → 9.
  - sel 1100 → 10.
  - sel 1101 → 11.
- BX tracking:
  - cur_bx is updated only by data words.
  - If have_bx=0 or the word's BX ≠ cur_bx:
    - all 12 counters clear, and the word is written at address 0;
    - bx_new=1;
    - bx_prev=cur_bx (0 when have_bx was 0);
    - all ovf bits clear;
    - cur_bx ← BX, have_bx ← 1.
  - Malformed and idle words never change BX state.
- Write:
  - The destination's counter value is presented on wr_addr, and the counter increments.
  - wr_en bit set; wr_dat and wr_bx driven from the word.
  - For non-write cycles, wr_en=0 and wr_addr/wr_dat/wr_bx hold their last values.
- Overflow:
  - If the destination counter already equals DEPTH, the write is suppressed (wr_en stays 0).
  - The counter holds at DEPTH and ovf[k] sets.
  - ovf[k] stays set until the next BX change or reset.
  - A new-BX word is never an overflow, because the counter restarts.
- Error counter:
  - Increments by 1 per malformed word.
  - Saturates at 2^ERR_W−1.
  - Cleared only by reset.
- Back-to-back words to the same destination get consecutive addresses with no bubble.

Test Plan:
- Reset, then idle stream (all 0) for 10 clocks → wr_en=0, bx_new=0, err_cnt=0 throughout.
- Words BX=3 with sel 0001, 0001, 1101 → wr_en=0x001 addr 0, 0x001 addr 1, 0x800 addr 0. The first word is also accompanied by bx_new=1 with bx_prev=0, and each word appears 2 clocks after input.
- Valid words with sel 1010, sel 0000 and header 2'b11 → no writes, err_cnt=3. A word with sel 1111 → no write, err_cnt unchanged.
- 65 words to destination 2 in BX=5 (ADDR_W=6) → addresses 0..63 are written, the 65th is suppressed, and ovf=0x004. A following BX=6 word to destination 2 → addr 0, bx_new=1, bx_prev=5, ovf=0.
- BX=1 word to destination 4 at addr 0, then a BX=2 word to destination 4 → addr 0 (not 1), bx_new=1, bx_prev=1.
- Assert reset_n=0 mid-BX (cur_bx=7, destination 0 counter at 3) with words still arriving, then release; the next BX=7 word to destination 0 → addr 0, bx_new=1, bx_prev=0. Also force 300 malformed words → err_cnt saturates at 255.
